spdr_spi_tx: RTL and testbench
==============================

# spdr_spi_tx

Read-side consumer for the byte FIFO. It sits in the FIFO's read clock domain and uses the FIFO's `dout`/`pop`/`empty` read port. Bytes are drained one at a time and shifted out MSB-first as an SPI mode-0 master, with chip select held across back-to-back bytes. Single clock domain; no clock crossing inside this block.

## Interface
- `CLK_DIV`, default 2: SCLK half-period in `clk_out` cycles; legal values are ≥1.
- `CS_HOLD`, default 2: cycles `cs_n` stays low after the last byte before the frame closes; legal values are ≥1.
- `clk_out`  in  1  the single clock; FIFO read-domain clock.
- `rst_in`  in  1  asynchronous, active-high reset.
- `enable`  in  1  when 1, new bytes may be drained; when 0, no new loads.
- `fifo_dout`  in  8  FIFO head byte; combinational and valid while `fifo_empty`=0.
- `fifo_empty`  in  1  FIFO empty flag.
- `fifo_pop`  out  1  combinational pop strobe; the FIFO advances on the clock edge where it is 1.
- `sclk`  out  1  SPI clock (registered, idles low).
- `mosi`  out  1  SPI data (registered).
- `cs_n`  out  1  SPI chip select, active low (registered).
- `busy`  out  1  1 whenever state ≠ IDLE.
- `byte_count`  out  8  count of bytes fully shifted out; wraps 255→0.

## Operation
- States: IDLE, SHIFT, HOLD.
- Load condition: `load = enable && !fifo_empty && !rst_in && (state==IDLE || state==HOLD || last cycle of a byte in SHIFT)`.
  - `fifo_pop = load`.
  - On the same edge, the shift register takes `fifo_dout`.
- IDLE:
  - `cs_n`=1, `sclk`=0, `mosi`=0.
  - If `load`: go to SHIFT, `cs_n`→0, `mosi`→bit7, divider←0, bit counter←0.
- SHIFT: each bit lasts 2·CLK_DIV cycles.
  - `sclk` is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - `mosi` changes only on falling edges of `sclk` (and at load). It is stable across every rising edge.
  - After the 8th high phase, `sclk` returns low and `byte_count` increments.
  - On that same edge: if `load`, the next byte starts with no gap and `cs_n` stays low. Otherwise go to HOLD.
- HOLD:
  - `cs_n`=0, `sclk`=0, `mosi`=0.
  - Hold counter runs CS_HOLD cycles.
  - If `load` in any HOLD cycle: go to SHIFT within the same frame (no `cs_n` toggle).
  - On expiry: `cs_n`→1, go to IDLE.
- `enable` falling mid-byte: the current byte completes normally. No further pop occurs. The frame closes via HOLD.
- `fifo_empty`/`fifo_dout` are sampled only in load cycles; changes at other times are ignored.
- Reset (async, any time): state IDLE, `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `byte_count`=0, counters 0, `fifo_pop`=0. A byte already popped but not fully sent is discarded.
- Widths:
  - divider: ⌈log2(CLK_DIV+1)⌉ bits.
  - bit counter: 3 bits.
  - hold counter: ⌈log2(CS_HOLD+1)⌉ bits.
  - `byte_count`: modulo 256.

## Timing
- Let E0 be the load edge (`fifo_pop`=1 in the cycle before E0).
  - `cs_n` falls at E0.
  - Rising `sclk` edges occur at E0+(2k+1)·CLK_DIV for k=0..7.
  - Falling `sclk` edges occur at E0+(2k+2)·CLK_DIV.
  - Byte ends at E0+16·CLK_DIV.
- Back-to-back bytes: pops are spaced exactly 16·CLK_DIV cycles apart. `sclk` is continuous, with no extra low cycles between bytes.
- Frame close with no new data: `cs_n` rises at E_end+CS_HOLD, where E_end is the last byte-end edge.
- Load latency: from `fifo_empty` falling (with `enable`=1) in IDLE/HOLD, `fifo_pop` is asserted in the same cycle.
- `byte_count` updates on the byte-end edge. `busy` falls on the same edge as `cs_n` rises.

## Test plan
- Reset values: assert `rst_in` with the FIFO non-empty and `enable`=1 → `fifo_pop`=0, `cs_n`=1, `sclk`=0, `mosi`=0, `busy`=0, `byte_count`=0.
- Single byte 0xA5, CLK_DIV=2, CS_HOLD=2 → one 1-cycle pop. Sampled `mosi` at 8 rising edges is 1,0,1,0,0,1,0,1. `cs_n` is low for 34 cycles. `byte_count`=1.
- Preloaded 0x3C, 0xFF, 0x00 → 24 rising edges and `cs_n` continuously low. Pops occur at 32-cycle spacing. Bits match all three bytes in order. `byte_count`=3.
- Second byte 0x81 arrives in HOLD cycle 1 → pop in that cycle and `cs_n` never rises. 16 total rising edges; second byte shifts 1,0,0,0,0,0,0,1.
- `enable`=0 during bit 3 of 0x55 with 2 bytes queued → 0x55 completes and no second pop. `cs_n` rises CS_HOLD cycles after byte end. `byte_count`=1.
- `rst_in` pulsed at bit 5 of a byte → outputs reach reset values asynchronously. After release with FIFO empty: `cs_n` stays 1 and `byte_count`=0.

Source files
------------

// File: rtl/spdr_spi_tx.sv
// spdr_spi_tx: drains bytes from the FIFO read port and shifts them out
// MSB-first as an SPI mode-0 master. Chip select stays low across
// back-to-back bytes and for CS_HOLD cycles after the last one.
module spdr_spi_tx #(
    parameter int CLK_DIV = 2,
    parameter int CS_HOLD = 2
) (
    input  logic       clk_out,
    input  logic       rst_in,
    input  logic       enable,
    input  logic [7:0] fifo_dout,
    input  logic       fifo_empty,
    output logic       fifo_pop,
    output logic       sclk,
    output logic       mosi,
    output logic       cs_n,
    output logic       busy,
    output logic [7:0] byte_count
);

    localparam int DIV_W  = $clog2(CLK_DIV + 1);
    localparam int HOLD_W = $clog2(CS_HOLD + 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(CS_HOLD - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_cnt;
    logic [2:0]        bit_cnt;
    logic [HOLD_W-1:0] hold_cnt;
    // Only the bits still to be sent after the current mosi value.
    logic [6:0]        shreg;

    logic phase_end;
    logic byte_end;
    logic load;

    assign phase_end = (div_cnt == DIV_LAST);
    // Last cycle of a byte: end of the 8th high phase.
    assign byte_end  = (state == SHIFT) && sclk && phase_end && (bit_cnt == 3'd7);
    assign load      = enable && !fifo_empty && !rst_in &&
                       ((state == IDLE) || (state == HOLD) || byte_end);
    assign fifo_pop  = load;
    assign busy      = (state != IDLE);

    // Frame sequencer: load, bit shifting with sclk generation, CS hold.
    always_ff @(posedge clk_out or posedge rst_in) begin
        if (rst_in) begin
            state      <= IDLE;
            div_cnt    <= '0;
            bit_cnt    <= '0;
            hold_cnt   <= '0;
            shreg      <= '0;
            sclk       <= 1'b0;
            mosi       <= 1'b0;
            cs_n       <= 1'b1;
            byte_count <= '0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (load) begin
                        state    <= SHIFT;
                        cs_n     <= 1'b0;
                        shreg    <= fifo_dout[6:0];
                        mosi     <= fifo_dout[7];
                        div_cnt  <= '0;
                        bit_cnt  <= '0;
                        hold_cnt <= '0;
                        sclk     <= 1'b0;
                    end else if (state == HOLD) begin
                        if (hold_cnt == HOLD_LAST) begin
                            state    <= IDLE;
                            cs_n     <= 1'b1;
                            hold_cnt <= '0;
                        end else begin
                            hold_cnt <= hold_cnt + HOLD_W'(1);
                        end
                    end
                end
                SHIFT: begin
                    if (!phase_end) begin
                        div_cnt <= div_cnt + DIV_W'(1);
                    end else begin
                        div_cnt <= '0;
                        if (!sclk) begin
                            sclk <= 1'b1;
                        end else begin
                            // Falling edge: next bit, or end of byte.
                            sclk <= 1'b0;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt    <= '0;
                                byte_count <= byte_count + 8'd1;
                                if (load) begin
                                    shreg <= fifo_dout[6:0];
                                    mosi  <= fifo_dout[7];
                                end else begin
                                    state    <= HOLD;
                                    mosi     <= 1'b0;
                                    hold_cnt <= '0;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                                mosi    <= shreg[6];
                                shreg   <= {shreg[5:0], 1'b0};
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spdr_spi_tx.sv
// tb_spdr_spi_tx: directed table-driven frames plus hand-written corner
// sequences (byte arriving in HOLD, enable drop mid-byte, async reset).
module tb_spdr_spi_tx;

    localparam int CLK_DIV = 2;
    localparam int CS_HOLD = 2;

    logic       clk_out = 1'b0;
    logic       rst_in;
    logic       enable;
    logic [7:0] fifo_dout;
    logic       fifo_empty;
    logic       fifo_pop;
    logic       sclk, mosi, cs_n, busy;
    logic [7:0] byte_count;

    spdr_spi_tx #(.CLK_DIV(CLK_DIV), .CS_HOLD(CS_HOLD)) dut (
        .clk_out(clk_out), .rst_in(rst_in), .enable(enable),
        .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_pop(fifo_pop),
        .sclk(sclk), .mosi(mosi), .cs_n(cs_n), .busy(busy),
        .byte_count(byte_count)
    );

    always #5 clk_out = ~clk_out;

    // FIFO model: written by the test, popped on the DUT's strobe
    logic [7:0] mem [256];
    logic [7:0] rd = 8'd0;
    logic [7:0] wr = 8'd0;
    logic       flush = 1'b0;
    assign fifo_dout  = mem[rd];
    assign fifo_empty = (rd == wr);

    // FIFO read pointer
    always @(posedge clk_out) begin
        if (flush) rd <= wr;
        else if (fifo_pop) rd <= rd + 8'd1;
    end

    // Bus monitor: free-running counters, sampled on the falling clk edge
    int         cyc = 0, edges = 0, cs_low = 0, cs_rise = 0, pops = 0;
    int         rise_cyc = 0, bc_cyc = 0, rx_bits = 0;
    logic [7:0] rx_sh = 8'd0, prev_bc = 8'd0, nb;
    logic       prev_sclk = 1'b0, prev_cs = 1'b1;
    logic [7:0] rx [$];
    int         pop_cyc [$];

    always @(negedge clk_out) begin
        cyc++;
        if (rst_in) rx_bits = 0;
        if (!prev_sclk && sclk) begin
            edges++;
            nb = {rx_sh[6:0], mosi};
            rx_sh = nb;
            rx_bits++;
            if (rx_bits % 8 == 0) rx.push_back(nb);
        end
        if (!cs_n) cs_low++;
        if (!prev_cs && cs_n) begin cs_rise++; rise_cyc = cyc; end
        if (byte_count != prev_bc) bc_cyc = cyc;
        if (fifo_pop) begin pops++; pop_cyc.push_back(cyc); end
        prev_sclk = sclk;
        prev_cs   = cs_n;
        prev_bc   = byte_count;
    end

    int nvec = 0, nerr = 0;
    int s_edges, s_cs_low, s_rise, s_pops, s_rx, s_pc;

    task automatic chk(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_out);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr] = b;
        wr = wr + 8'd1;
    endtask

    task automatic mark();
        s_edges = edges; s_cs_low = cs_low; s_rise = cs_rise;
        s_pops = pops; s_rx = rx.size(); s_pc = pop_cyc.size();
    endtask

    task automatic do_reset();
        enable = 1'b0;
        rst_in = 1'b1;
        flush  = 1'b1;
        step(2);
        flush  = 1'b0;
        rst_in = 1'b0;
        step(1);
    endtask

    task automatic wait_idle(input string nm, input int limit);
        bit ok = 0;
        for (int i = 0; i < limit; i++) begin
            step(1);
            if (cs_rise > s_rise && !busy) begin ok = 1; break; end
        end
        chk({nm, "_frame_done"}, int'(ok), 1);
    endtask

    function automatic int rx_at(input int idx);
        if (idx < rx.size()) return int'(rx[idx]);
        return -1;
    endfunction

    typedef struct {
        string      nm;
        int         n;
        logic [7:0] b0, b1, b2;
        int         exp_edges;
        int         exp_cs_low;
        int         exp_bc;
    } vec_t;

    function automatic vec_t mk(input string nm, input int n, input logic [7:0] b0,
                                input logic [7:0] b1, input logic [7:0] b2,
                                input int e, input int cl, input int bc);
        vec_t v;
        v.nm = nm; v.n = n; v.b0 = b0; v.b1 = b1; v.b2 = b2;
        v.exp_edges = e; v.exp_cs_low = cl; v.exp_bc = bc;
        return v;
    endfunction

    vec_t       tbl [4];
    logic [7:0] bytes [3];

    initial begin
        // cs_n low = 32 cycles per byte + CS_HOLD
        tbl[0] = mk("single_a5",   1, 8'hA5, 8'h00, 8'h00,  8, 34, 1);
        tbl[1] = mk("three_bytes", 3, 8'h3C, 8'hFF, 8'h00, 24, 98, 3);
        tbl[2] = mk("two_bytes",   2, 8'h55, 8'hAA, 8'h00, 16, 66, 2);
        tbl[3] = mk("single_00",   1, 8'h00, 8'h00, 8'h00,  8, 34, 1);

        // Reset with data waiting and enable high
        rst_in = 1'b1;
        enable = 1'b1;
        push(8'hAA);
        step(2);
        chk("rst_pop",   int'(fifo_pop), 0);
        chk("rst_cs_n",  int'(cs_n), 1);
        chk("rst_sclk",  int'(sclk), 0);
        chk("rst_mosi",  int'(mosi), 0);
        chk("rst_busy",  int'(busy), 0);
        chk("rst_count", int'(byte_count), 0);

        // Table-driven preloaded frames
        for (int i = 0; i < 4; i++) begin
            do_reset();
            mark();
            bytes[0] = tbl[i].b0; bytes[1] = tbl[i].b1; bytes[2] = tbl[i].b2;
            for (int j = 0; j < tbl[i].n; j++) push(bytes[j]);
            enable = 1'b1;
            wait_idle(tbl[i].nm, 2000);
            step(5);
            chk({tbl[i].nm, "_edges"},  edges - s_edges, tbl[i].exp_edges);
            chk({tbl[i].nm, "_cs_low"}, cs_low - s_cs_low, tbl[i].exp_cs_low);
            chk({tbl[i].nm, "_frames"}, cs_rise - s_rise, 1);
            chk({tbl[i].nm, "_pops"},   pops - s_pops, tbl[i].n);
            chk({tbl[i].nm, "_count"},  int'(byte_count), tbl[i].exp_bc);
            for (int j = 0; j < tbl[i].n; j++)
                chk({tbl[i].nm, "_byte"}, rx_at(s_rx + j), int'(bytes[j]));
            for (int j = 1; j < tbl[i].n; j++) begin
                if (s_pc + j < pop_cyc.size())
                    chk({tbl[i].nm, "_pop_gap"}, pop_cyc[s_pc + j] - pop_cyc[s_pc + j - 1], 32);
                else
                    chk({tbl[i].nm, "_pop_gap"}, -1, 32);
            end
        end

        // Second byte arrives in the first HOLD cycle
        begin
            bit ok = 0;
            do_reset();
            mark();
            push(8'hC3);
            enable = 1'b1;
            for (int i = 0; i < 200; i++) begin
                step(1);
                if (byte_count == 8'd1) begin ok = 1; break; end
            end
            chk("hold_first_done", int'(ok), 1);
            chk("hold_cs_low", int'(cs_n), 0);
            chk("hold_busy", int'(busy), 1);
            push(8'h81);
            #1;
            chk("hold_pop", int'(fifo_pop), 1);
            wait_idle("hold", 2000);
            step(5);
            chk("hold_edges", edges - s_edges, 16);
            chk("hold_frames", cs_rise - s_rise, 1);
            chk("hold_cs_low_cycles", cs_low - s_cs_low, 67);
            chk("hold_byte2", rx_at(s_rx + 1), 8'h81);
            chk("hold_count", int'(byte_count), 2);
        end

        // enable drops during bit 3 with a second byte queued
        do_reset();
        mark();
        push(8'h55);
        push(8'h66);
        enable = 1'b1;
        step(1);
        step(13);
        enable = 1'b0;
        wait_idle("endrop", 2000);
        step(5);
        chk("endrop_pops", pops - s_pops, 1);
        chk("endrop_count", int'(byte_count), 1);
        chk("endrop_edges", edges - s_edges, 8);
        chk("endrop_byte", rx_at(s_rx), 8'h55);
        chk("endrop_hold_len", rise_cyc - bc_cyc, CS_HOLD);

        // Asynchronous reset in the middle of bit 5
        do_reset();
        push(8'hF0);
        push(8'h0F);
        enable = 1'b1;
        step(1);
        step(20);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_pop",   int'(fifo_pop), 0);
        chk("arst_cs_n",  int'(cs_n), 1);
        chk("arst_sclk",  int'(sclk), 0);
        chk("arst_mosi",  int'(mosi), 0);
        chk("arst_busy",  int'(busy), 0);
        chk("arst_count", int'(byte_count), 0);
        flush = 1'b1;
        step(1);
        flush  = 1'b0;
        rst_in = 1'b0;
        step(1);
        mark();
        step(40);
        chk("arst_after_edges",  edges - s_edges, 0);
        chk("arst_after_cs_low", cs_low - s_cs_low, 0);
        chk("arst_after_cs_n",   int'(cs_n), 1);
        chk("arst_after_count",  int'(byte_count), 0);
        chk("arst_after_pops",   pops - s_pops, 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
